// File: rtl/pll_seq_pkg.sv
// Shared state encoding and parameter defaults for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_PWRDN     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam int RST_CYC_DEF      = 16;
    localparam int LOCK_TIMEOUT_DEF = 100000;
    localparam int SETTLE_CYC_DEF   = 1024;
    localparam int MAX_RETRY_DEF    = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL reset/lock/settle sequencer with retry, failure and power-down handling.
// Optional lock-loss counter enabled by defining PLLSEQ_LOSS_CNT_EN.
module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYC      = RST_CYC_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int SETTLE_CYC   = SETTLE_CYC_DEF,
    parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_i,
    input  logic       pwrdn_req_i,
    output logic       pll_rst_o,
    output logic       pll_pwrdn_o,
    output logic       dom_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    localparam int TW = $clog2(max3(RST_CYC, LOCK_TIMEOUT, SETTLE_CYC)) + 1;
    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    logic lock;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock_i),
        .q   (lock)
    );

    state_t          state_reg,  state_next;
    logic [TW-1:0]   timer_reg,  timer_next;
    logic [3:0]      retry_reg,  retry_next;
    logic            pll_rst_reg,   pll_rst_next;
    logic            pll_pwrdn_reg, pll_pwrdn_next;
    logic            dom_rst_reg,   dom_rst_next;
    logic            ready_reg,     ready_next;
    logic            fail_reg,      fail_next;

    always_comb begin
        state_next = state_reg;
        timer_next = '0;
        retry_next = retry_reg;

        case (state_reg)
            ST_PLL_RST: begin
                if (timer_reg == RST_LAST) state_next = ST_WAIT_LOCK;
                else                       timer_next = timer_reg + 1'b1;
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as a lock.
                if (lock) begin
                    state_next = ST_SETTLE;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    retry_next = retry_reg + 4'd1;
                    state_next = (retry_reg + 4'd1 == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!lock) begin
                    state_next = ST_WAIT_LOCK;
                end else if (timer_reg == SETTLE_LAST) begin
                    state_next = ST_RUN;
                    retry_next = 4'd0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock) state_next = ST_PLL_RST;
            end
            ST_PWRDN: begin
                if (!pwrdn_req_i) begin
                    state_next = ST_PLL_RST;
                    retry_next = 4'd0;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_PLL_RST;
            end
        endcase

        if (pwrdn_req_i) begin
            state_next = ST_PWRDN;
            timer_next = '0;
            retry_next = retry_reg;
        end

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_next   = (state_next != ST_WAIT_LOCK) && (state_next != ST_SETTLE)
                         && (state_next != ST_RUN);
        pll_pwrdn_next = (state_next == ST_PWRDN);
        dom_rst_next   = (state_next != ST_RUN);
        ready_next     = (state_next == ST_RUN);
        fail_next      = (state_next == ST_FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_PLL_RST;
            timer_reg     <= '0;
            retry_reg     <= 4'd0;
            pll_rst_reg   <= 1'b1;
            pll_pwrdn_reg <= 1'b0;
            dom_rst_reg   <= 1'b1;
            ready_reg     <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            retry_reg     <= retry_next;
            pll_rst_reg   <= pll_rst_next;
            pll_pwrdn_reg <= pll_pwrdn_next;
            dom_rst_reg   <= dom_rst_next;
            ready_reg     <= ready_next;
            fail_reg      <= fail_next;
        end
    end

`ifdef PLLSEQ_LOSS_CNT_EN
    logic       loss_inc;
    logic [7:0] loss_reg;

    assign loss_inc = (state_reg == ST_RUN) && !lock && !pwrdn_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              loss_reg <= 8'd0;
        else if (loss_inc && loss_reg != 8'hFF) loss_reg <= loss_reg + 8'd1;
    end

    assign loss_cnt_o = loss_reg;
`else
    assign loss_cnt_o = 8'd0;
`endif

    assign pll_rst_o   = pll_rst_reg;
    assign pll_pwrdn_o = pll_pwrdn_reg;
    assign dom_rst_o   = dom_rst_reg;
    assign ready_o     = ready_reg;
    assign fail_o      = fail_reg;
    assign state_o     = state_reg;
    assign retry_cnt_o = retry_reg;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with RST_CYC=4, LOCK_TIMEOUT=20, SETTLE_CYC=8, MAX_RETRY=3.
module tb_pll_lock_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_i = 1'b0;
    logic       pwrdn_req_i = 1'b0;
    logic       pll_rst_o, pll_pwrdn_o, dom_rst_o, ready_o, fail_o;
    logic [2:0] state_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_loss;

    always #5 clk = ~clk;

    pll_lock_seq #(
        .RST_CYC      (4),
        .LOCK_TIMEOUT (20),
        .SETTLE_CYC   (8),
        .MAX_RETRY    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lock_i      (lock_i),
        .pwrdn_req_i (pwrdn_req_i),
        .pll_rst_o   (pll_rst_o),
        .pll_pwrdn_o (pll_pwrdn_o),
        .dom_rst_o   (dom_rst_o),
        .ready_o     (ready_o),
        .fail_o      (fail_o),
        .state_o     (state_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o)
    );

    // One clock edge, then settle 1ns past it; "after edge k" below counts these.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves rst released just after an edge; the next edge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ticks(2);
        total++; if (pll_rst_o !== 1'b1)   begin bad++; $display("FAIL reset_pll_rst got=%0b exp=1", pll_rst_o); end
        total++; if (pll_pwrdn_o !== 1'b0) begin bad++; $display("FAIL reset_pwrdn got=%0b exp=0", pll_pwrdn_o); end
        total++; if (dom_rst_o !== 1'b1)   begin bad++; $display("FAIL reset_dom_rst got=%0b exp=1", dom_rst_o); end
        total++; if (ready_o !== 1'b0)     begin bad++; $display("FAIL reset_ready got=%0b exp=0", ready_o); end
        total++; if (fail_o !== 1'b0)      begin bad++; $display("FAIL reset_fail got=%0b exp=0", fail_o); end
        total++; if (state_o !== 3'd0)     begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++; if (retry_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_retry got=%0d exp=0", retry_cnt_o); end
        total++; if (loss_cnt_o !== 8'd0)  begin bad++; $display("FAIL reset_loss got=%0d exp=0", loss_cnt_o); end
        $display("test_reset: done");
    endtask

    task automatic test_lock_seq();
        lock_i = 1'b0;
        do_reset();
        ticks(3);
        total++; if (pll_rst_o !== 1'b1) begin bad++; $display("FAIL seq_pll_rst_e3 got=%0b exp=1", pll_rst_o); end
        tick();
        total++; if (pll_rst_o !== 1'b0) begin bad++; $display("FAIL seq_pll_rst_e4 got=%0b exp=0", pll_rst_o); end
        total++; if (state_o !== 3'd1)   begin bad++; $display("FAIL seq_state_e4 got=%0d exp=1", state_o); end
        ticks(6);
        lock_i = 1'b1;
        ticks(2);
        total++; if (state_o !== 3'd1)   begin bad++; $display("FAIL seq_state_e12 got=%0d exp=1", state_o); end
        tick();
        total++; if (state_o !== 3'd2)   begin bad++; $display("FAIL seq_state_e13 got=%0d exp=2", state_o); end
        ticks(7);
        total++; if (ready_o !== 1'b0 || dom_rst_o !== 1'b1)
            begin bad++; $display("FAIL seq_e20 got ready=%0b dom_rst=%0b exp ready=0 dom_rst=1", ready_o, dom_rst_o); end
        tick();
        total++; if (ready_o !== 1'b1 || dom_rst_o !== 1'b0 || state_o !== 3'd3)
            begin bad++; $display("FAIL seq_e21 got ready=%0b dom_rst=%0b state=%0d exp 1 0 3", ready_o, dom_rst_o, state_o); end
        $display("test_lock_seq: done");
    endtask

    // Expects to start in RUN with lock_i high.
    task automatic test_lock_loss();
        lock_i = 1'b0;
        tick();
        lock_i = 1'b1;
        tick();
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL loss_state_n2 got=%0d exp=3", state_o); end
        tick();
        total++; if (state_o !== 3'd0 || ready_o !== 1'b0 || dom_rst_o !== 1'b1)
            begin bad++; $display("FAIL loss_n3 got state=%0d ready=%0b dom_rst=%0b exp 0 0 1", state_o, ready_o, dom_rst_o); end
        total++; if (loss_cnt_o !== exp_loss) begin bad++; $display("FAIL loss_cnt got=%0d exp=%0d", loss_cnt_o, exp_loss); end
        $display("test_lock_loss: done");
    endtask

    task automatic test_settle_glitch();
        lock_i = 1'b0;
        do_reset();
        ticks(4);
        lock_i = 1'b1;
        ticks(3);
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL glitch_state_e7 got=%0d exp=2", state_o); end
        ticks(4);
        lock_i = 1'b0;
        tick();
        lock_i = 1'b1;
        tick();
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL glitch_state_e13 got=%0d exp=2", state_o); end
        tick();
        total++; if (state_o !== 3'd1 || retry_cnt_o !== 4'd0)
            begin bad++; $display("FAIL glitch_e14 got state=%0d retry=%0d exp 1 0", state_o, retry_cnt_o); end
        tick();
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL glitch_state_e15 got=%0d exp=2", state_o); end
        ticks(7);
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL glitch_state_e22 got=%0d exp=2", state_o); end
        tick();
        total++; if (state_o !== 3'd3 || ready_o !== 1'b1)
            begin bad++; $display("FAIL glitch_e23 got state=%0d ready=%0b exp 3 1", state_o, ready_o); end
        $display("test_settle_glitch: done");
    endtask

    // Expects to start in RUN.
    task automatic test_pwrdn_override();
        pwrdn_req_i = 1'b1;
        tick();
        total++; if (state_o !== 3'd4 || ready_o !== 1'b0 || dom_rst_o !== 1'b1 || pll_pwrdn_o !== 1'b1)
            begin bad++; $display("FAIL ovr_pwrdn got state=%0d ready=%0b dom_rst=%0b pwrdn=%0b exp 4 0 1 1",
                                  state_o, ready_o, dom_rst_o, pll_pwrdn_o); end
        pwrdn_req_i = 1'b0;
        tick();
        total++; if (state_o !== 3'd0 || pll_pwrdn_o !== 1'b0)
            begin bad++; $display("FAIL ovr_exit got state=%0d pwrdn=%0b exp 0 0", state_o, pll_pwrdn_o); end
        $display("test_pwrdn_override: done");
    endtask

    task automatic test_timeout_fail();
        lock_i = 1'b0;
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            ticks(23);
            total++; if (state_o !== 3'd1 || retry_cnt_o !== 4'(r - 1))
                begin bad++; $display("FAIL to_wait_r%0d got state=%0d retry=%0d exp 1 %0d", r, state_o, retry_cnt_o, r - 1); end
            tick();
            total++; if (retry_cnt_o !== 4'(r) || state_o !== ((r < 3) ? 3'd0 : 3'd5))
                begin bad++; $display("FAIL to_expire_r%0d got state=%0d retry=%0d exp %0d %0d",
                                      r, state_o, retry_cnt_o, (r < 3) ? 0 : 5, r); end
        end
        ticks(5);
        total++; if (fail_o !== 1'b1 || state_o !== 3'd5 || pll_rst_o !== 1'b1 || dom_rst_o !== 1'b1)
            begin bad++; $display("FAIL to_hold got fail=%0b state=%0d pll_rst=%0b dom_rst=%0b exp 1 5 1 1",
                                  fail_o, state_o, pll_rst_o, dom_rst_o); end
        $display("test_timeout_fail: done");
    endtask

    // Expects to start in FAIL with retry_cnt_o=3.
    task automatic test_pwrdn_from_fail();
        pwrdn_req_i = 1'b1;
        tick();
        total++; if (state_o !== 3'd4 || pll_pwrdn_o !== 1'b1 || pll_rst_o !== 1'b1 || retry_cnt_o !== 4'd3)
            begin bad++; $display("FAIL pd_enter got state=%0d pwrdn=%0b pll_rst=%0b retry=%0d exp 4 1 1 3",
                                  state_o, pll_pwrdn_o, pll_rst_o, retry_cnt_o); end
        tick();
        pwrdn_req_i = 1'b0;
        tick();
        total++; if (state_o !== 3'd0 || fail_o !== 1'b0 || retry_cnt_o !== 4'd0 || pll_pwrdn_o !== 1'b0)
            begin bad++; $display("FAIL pd_exit got state=%0d fail=%0b retry=%0d pwrdn=%0b exp 0 0 0 0",
                                  state_o, fail_o, retry_cnt_o, pll_pwrdn_o); end
        $display("test_pwrdn_from_fail: done");
    endtask

    task automatic test_async_reset();
        lock_i = 1'b1;
        do_reset();
        ticks(6);
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL ar_settle got=%0d exp=2", state_o); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (state_o !== 3'd0 || pll_rst_o !== 1'b1 || dom_rst_o !== 1'b1 || ready_o !== 1'b0 ||
                     pll_pwrdn_o !== 1'b0 || fail_o !== 1'b0 || retry_cnt_o !== 4'd0 || loss_cnt_o !== 8'd0)
            begin bad++; $display("FAIL ar_immediate got state=%0d pll_rst=%0b dom_rst=%0b ready=%0b pwrdn=%0b fail=%0b retry=%0d loss=%0d",
                                  state_o, pll_rst_o, dom_rst_o, ready_o, pll_pwrdn_o, fail_o, retry_cnt_o, loss_cnt_o); end
        tick();
        rst = 1'b0;
        ticks(3);
        total++; if (pll_rst_o !== 1'b1) begin bad++; $display("FAIL ar_pulse_e3 got=%0b exp=1", pll_rst_o); end
        tick();
        total++; if (pll_rst_o !== 1'b0 || state_o !== 3'd1)
            begin bad++; $display("FAIL ar_pulse_e4 got pll_rst=%0b state=%0d exp 0 1", pll_rst_o, state_o); end
        $display("test_async_reset: done");
    endtask

    initial begin
`ifdef PLLSEQ_LOSS_CNT_EN
        exp_loss = 8'd1;
`else
        exp_loss = 8'd0;
`endif
        test_reset();
        test_lock_seq();
        test_lock_loss();
        test_settle_glitch();
        test_pwrdn_override();
        test_timeout_fail();
        test_pwrdn_from_fail();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
